// File: rtl/dmem_responder.sv
// Word-organised data memory responder: valid/ready request, programmable wait states, byte/half/word lanes.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_we,
  input  logic              i_byte,
  input  logic              i_half,
  input  logic              i_word,
  input  logic              i_unsigned,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rdata,
  output logic              o_err
);

  localparam int          DEPTH     = 1 << (ADDR_W - 2);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // size is one-hot {word, half, byte} when legal
  typedef struct packed {
    logic              we;
    logic [2:0]        size;
    logic              unsgn;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  req_t        req_q;
  req_t        in_req;
  req_t        cur;
  logic        commit;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-3:0] word_idx;
  logic [1:0]        lane;
  logic              size_ok;
  logic              misalign;
  logic              acc_err;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_data;
  logic              write_en;

  assign in_req = '{we: i_we, size: {i_word, i_half, i_byte}, unsgn: i_unsigned,
                    addr: i_addr, wdata: i_wdata};

  // With zero wait states the access commits on the accept edge, so decode the live request.
  assign cur = (state == IDLE) ? in_req : req_q;

  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);

  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    size_ok = (cur.size == 3'b001) || (cur.size == 3'b010) || (cur.size == 3'b100);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = (cur.size[1] & cur.addr[0]) | (cur.size[2] & (|cur.addr[1:0]));
`else
    misalign = 1'b0;
`endif
    acc_err  = !size_ok || misalign;
    word_idx = cur.addr[ADDR_W-1:2];

    lane   = 2'b00;
    be     = 4'b1111;
    wlanes = cur.wdata;
    if (cur.size[0]) begin
      lane   = cur.addr[1:0];
      be     = 4'b0001 << lane;
      wlanes = {4{cur.wdata[7:0]}};
    end else if (cur.size[1]) begin
      lane   = {cur.addr[1], 1'b0};
      be     = 4'b0011 << lane;
      wlanes = {2{cur.wdata[15:0]}};
    end

    rd_word = mem[word_idx];
    shifted = rd_word >> {lane, 3'b000};
    if (cur.size[0])
      load_data = cur.unsgn ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (cur.size[1])
      load_data = cur.unsgn ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
    else
      load_data = shifted;

    write_en = commit & cur.we & !acc_err & !rst;
  end

  // NOTE: the array has no reset; clearing it would cost a reset port on every bit of storage.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      req_q   <= '0;
      o_rdata <= 32'd0;
      o_err   <= 1'b0;
    end else begin
      state <= state_next;

      if (state == IDLE && i_req_valid) begin
        req_q <= in_req;
        cnt   <= WAIT_INIT;
      end else if (state == WAIT && cnt > 4'd1) begin
        cnt <= cnt - 4'd1;
      end

      if (commit) begin
        o_err   <= acc_err;
        o_rdata <= (acc_err || cur.we) ? 32'd0 : load_data;
      end else if (state == RESP && i_rsp_ready) begin
        o_err   <= 1'b0;
        o_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES = 3); expectations follow DMEM_MISALIGN_TRAP_EN if defined.
module tb_dmem_responder;

  localparam int ADDR_W = 12;
  localparam int WAIT_C = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_we;
  logic              i_byte;
  logic              i_half;
  logic              i_word;
  logic              i_unsigned;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [31:0]       o_rdata;
  logic              o_err;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] SZ_B = 3'b001;
  localparam logic [2:0] SZ_H = 3'b010;
  localparam logic [2:0] SZ_W = 3'b100;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_C)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_we       (i_we),
    .i_byte     (i_byte),
    .i_half     (i_half),
    .i_word     (i_word),
    .i_unsigned (i_unsigned),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rdata    (o_rdata),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drive a request at a negedge, accept it, and wait (bounded) for the response.
  task automatic issue(input logic we, input logic [2:0] sz, input logic uns,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       output int lat);
    @(negedge clk);
    check("req_ready_before_accept", 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1;
    i_we        = we;
    {i_word, i_half, i_byte} = sz;
    i_unsigned  = uns;
    i_addr      = addr;
    i_wdata     = wd;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    lat = 0;
    while (!o_rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_arrives", 32'(o_rsp_valid), 32'd1);
  endtask

  task automatic finish_rsp();
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check("post_hs_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("post_hs_rdata", o_rdata, 32'd0);
    check("post_hs_req_ready", 32'(o_req_ready), 32'd1);
  endtask

  task automatic access(input string tag, input logic we, input logic [2:0] sz, input logic uns,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    issue(we, sz, uns, addr, wd, lat);
    check({tag, "_latency"}, 32'(lat), 32'(WAIT_C));
    check({tag, "_rdata"}, o_rdata, exp_rdata);
    check({tag, "_err"}, 32'(o_err), 32'(exp_err));
    finish_rsp();
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    rst = 1'b1;
    i_req_valid = 1'b0; i_we = 1'b0; i_byte = 1'b0; i_half = 1'b0; i_word = 1'b0;
    i_unsigned = 1'b0; i_addr = '0; i_wdata = '0; i_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(o_req_ready), 32'd1);
    check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset_rdata", o_rdata, 32'd0);
    check("reset_err", 32'(o_err), 32'd0);
    rst = 1'b0;

    // Reset mid-WAIT discards the pending store.
    access("sw_010_init", 1'b1, SZ_W, 1'b0, 12'h010, 32'h1111_1111, 32'd0, 1'b0);
    @(negedge clk);
    i_req_valid = 1'b1; i_we = 1'b1; {i_word, i_half, i_byte} = SZ_W;
    i_addr = 12'h010; i_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    check("mid_wait_req_ready", 32'(o_req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_mid_rsp_valid", 32'(o_rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_stays_idle", 32'(o_rsp_valid), 32'd0);
    access("lw_010_after_rst", 1'b0, SZ_W, 1'b0, 12'h010, 32'd0, 32'h1111_1111, 1'b0);

    // Word store/load.
    access("sw_020", 1'b1, SZ_W, 1'b0, 12'h020, 32'h8000_00F0, 32'd0, 1'b0);
    access("lw_020", 1'b0, SZ_W, 1'b0, 12'h020, 32'd0, 32'h8000_00F0, 1'b0);

    // Byte lanes; store data is right-aligned so upper bits must be ignored.
    access("sb_023", 1'b1, SZ_B, 1'b0, 12'h023, 32'hABCD_EF7F, 32'd0, 1'b0);
    access("lb_023", 1'b0, SZ_B, 1'b0, 12'h023, 32'd0, 32'h0000_007F, 1'b0);
    access("lb_020", 1'b0, SZ_B, 1'b0, 12'h020, 32'd0, 32'hFFFF_FFF0, 1'b0);
    access("lbu_020", 1'b0, SZ_B, 1'b1, 12'h020, 32'd0, 32'h0000_00F0, 1'b0);
    access("lw_020_merged", 1'b0, SZ_W, 1'b0, 12'h020, 32'd0, 32'h7F00_00F0, 1'b0);

    // Half lanes.
    access("sw_030_zero", 1'b1, SZ_W, 1'b0, 12'h030, 32'h0000_0000, 32'd0, 1'b0);
    access("sh_032", 1'b1, SZ_H, 1'b0, 12'h032, 32'h1234_BEEF, 32'd0, 1'b0);
    access("lh_032", 1'b0, SZ_H, 1'b0, 12'h032, 32'd0, 32'hFFFF_BEEF, 1'b0);
    access("lhu_032", 1'b0, SZ_H, 1'b1, 12'h032, 32'd0, 32'h0000_BEEF, 1'b0);
    access("lw_030", 1'b0, SZ_W, 1'b0, 12'h030, 32'd0, 32'hBEEF_0000, 1'b0);

    // Misalignment.
`ifdef DMEM_MISALIGN_TRAP_EN
    access("lw_021_misal", 1'b0, SZ_W, 1'b0, 12'h021, 32'd0, 32'd0, 1'b1);
    access("lh_033_misal", 1'b0, SZ_H, 1'b0, 12'h033, 32'd0, 32'd0, 1'b1);
    access("sw_031_misal", 1'b1, SZ_W, 1'b0, 12'h031, 32'h9999_9999, 32'd0, 1'b1);
    access("lw_030_after_misal", 1'b0, SZ_W, 1'b0, 12'h030, 32'd0, 32'hBEEF_0000, 1'b0);
`else
    access("lw_021_misal", 1'b0, SZ_W, 1'b0, 12'h021, 32'd0, 32'h7F00_00F0, 1'b0);
    access("lh_033_misal", 1'b0, SZ_H, 1'b0, 12'h033, 32'd0, 32'hFFFF_BEEF, 1'b0);
    access("sw_031_misal", 1'b1, SZ_W, 1'b0, 12'h031, 32'h9999_9999, 32'd0, 1'b0);
    access("lw_030_after_misal", 1'b0, SZ_W, 1'b0, 12'h030, 32'd0, 32'h9999_9999, 1'b0);
`endif

    // Backpressure: response held for 5 cycles.
    issue(1'b0, SZ_W, 1'b0, 12'h020, 32'd0, lat);
    check("bp_latency", 32'(lat), 32'(WAIT_C));
    held = 32'h7F00_00F0;
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      check("bp_rdata", o_rdata, held);
      check("bp_req_ready", 32'(o_req_ready), 32'd0);
      @(negedge clk);
    end
    finish_rsp();

    // Illegal sizes: error, no write.
    access("sbw_020_illegal", 1'b1, 3'b101, 1'b0, 12'h020, 32'hAAAA_AAAA, 32'd0, 1'b1);
    access("load_nosize", 1'b0, 3'b000, 1'b0, 12'h020, 32'd0, 32'd0, 1'b1);
    access("lw_020_unchanged", 1'b0, SZ_W, 1'b0, 12'h020, 32'd0, 32'h7F00_00F0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
